// File: rtl/osc_sweep_ctrl_if.sv
// osc_sweep_ctrl_if: result-record valid/ready channel from the sweep controller to the logger
// master drives res_valid/res_vec/res_osc/res_toggles and samples res_ready; slave is the reverse
interface osc_sweep_ctrl_if #(
  parameter int VEC_W = 8,
  parameter int CNT_W = 4
);
  logic             res_valid;
  logic             res_ready;
  logic [VEC_W-1:0] res_vec;
  logic             res_osc;
  logic [CNT_W-1:0] res_toggles;
  modport master (output res_valid, res_vec, res_osc, res_toggles, input res_ready);
  modport slave  (input res_valid, res_vec, res_osc, res_toggles, output res_ready);
endinterface

// File: rtl/osc_sweep_ctrl.sv
// osc_sweep_ctrl: exhaustive stimulus sweep for combLogic with settle/observe windows and per-vector result records
// clk, rst (async, active-high); start/abort control; vec_out stimulus; osc_flag_in/node_in observed;
// rs (master) result channel; osc_count oscillating-vector tally; busy during sweep; done one-cycle pulse
module osc_sweep_ctrl #(
  parameter int VEC_W      = 8,
  parameter int NODE_W     = 14,
  parameter int SETTLE_CYC = 4,
  parameter int OBS_CYC    = 8,
  parameter int CNT_W      = $clog2(OBS_CYC + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic [VEC_W-1:0]    vec_out,
  input  logic                osc_flag_in,
  input  logic [NODE_W-1:0]   node_in,
  osc_sweep_ctrl_if.master    rs,
  output logic [VEC_W:0]      osc_count,
  output logic                busy,
  output logic                done
);
  localparam int MAXC = (SETTLE_CYC > OBS_CYC) ? SETTLE_CYC : OBS_CYC;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  typedef enum logic [2:0] {IDLE, SETTLE, OBSERVE, REPORT, DONE} state_t;
  state_t            state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [VEC_W:0]    osc_cnt_q, osc_cnt_d;
  logic [NODE_W-1:0] node_prev_q, node_prev_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  tog_q, tog_d;
  logic              last, hs, launch, timed;
  assign last   = vec_q == '1;
  assign hs     = state_q == REPORT && rs.res_ready && !abort;
  assign launch = state_q == IDLE && state_d == SETTLE;
  assign timed  = state_q == SETTLE || state_q == OBSERVE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (start && !abort) ? SETTLE : IDLE;
      SETTLE:  state_d = abort ? IDLE : (cnt_q == TW'(SETTLE_CYC - 1)) ? OBSERVE : SETTLE;
      OBSERVE: state_d = abort ? IDLE : (cnt_q == TW'(OBS_CYC - 1)) ? REPORT : OBSERVE;
      REPORT:  state_d = abort ? IDLE : !rs.res_ready ? REPORT : last ? DONE : SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rs.res_valid   = state_q == REPORT;
    rs.res_vec     = vec_q;
    rs.res_osc     = sticky_q;
    rs.res_toggles = tog_q;
    vec_out        = vec_q;
    osc_count      = osc_cnt_q;
    busy           = timed || state_q == REPORT;
    done           = state_q == DONE;
  end
  always_comb begin
    cnt_d       = (timed && state_d == state_q) ? cnt_q + TW'(1) : '0;
    vec_d       = launch ? '0 : (hs && !last) ? vec_q + VEC_W'(1) : vec_q;
    osc_cnt_d   = launch ? '0 : (hs && sticky_q) ? osc_cnt_q + (VEC_W+1)'(1) : osc_cnt_q;
    node_prev_d = timed ? node_in : node_prev_q;
    sticky_d    = (state_q == SETTLE) ? 1'b0 : (state_q == OBSERVE) ? (sticky_q | osc_flag_in) : sticky_q;
    tog_d       = (state_q == SETTLE) ? '0 :
                  (state_q == OBSERVE && node_in != node_prev_q && tog_q != '1) ? tog_q + CNT_W'(1) : tog_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q       <= '0;
      vec_q       <= '0;
      osc_cnt_q   <= '0;
      node_prev_q <= '0;
      sticky_q    <= 1'b0;
      tog_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      osc_cnt_q   <= osc_cnt_d;
      node_prev_q <= node_prev_d;
      sticky_q    <= sticky_d;
      tog_q       <= tog_d;
    end
endmodule

// File: tb/tb_osc_sweep_ctrl.sv
// tb_osc_sweep_ctrl: directed self-checking bench for osc_sweep_ctrl
module tb_osc_sweep_ctrl;
  localparam int VEC_W = 8, NODE_W = 14, SETTLE_CYC = 4, OBS_CYC = 8, CNT_W = 4;
  logic clk = 0, rst = 1, start = 0, abort = 0, tog_mode = 0;
  logic [VEC_W-1:0] vec_out;
  logic osc_flag_in;
  logic [NODE_W-1:0] node_in = '0;
  logic [VEC_W:0] osc_count;
  logic busy, done;
  int tests = 0, fails = 0;
  osc_sweep_ctrl_if #(.VEC_W(VEC_W), .CNT_W(CNT_W)) rs ();
  osc_sweep_ctrl #(.VEC_W(VEC_W), .NODE_W(NODE_W), .SETTLE_CYC(SETTLE_CYC), .OBS_CYC(OBS_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_out(vec_out), .osc_flag_in(osc_flag_in),
    .node_in(node_in), .rs(rs.master), .osc_count(osc_count), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic osc_model(input logic [7:0] v);
    return (v == 8'hEE) || (v[7:3] == 5'b00011) || (v == 8'h05) || (v == 8'hAA);
  endfunction
  assign osc_flag_in = osc_model(vec_out);
  initial forever begin
    @(negedge clk);
    if (tog_mode) node_in = ~node_in;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_vec_out"}, vec_out, 0);
    check({tag, "_res_valid"}, rs.res_valid, 0);
    check({tag, "_res_vec"}, rs.res_vec, 0);
    check({tag, "_res_osc"}, rs.res_osc, 0);
    check({tag, "_res_toggles"}, rs.res_toggles, 0);
    check({tag, "_osc_count"}, osc_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask
  initial begin
    int cyc, first_valid, nrec, n_osc, done_cyc, w;
    logic seen_ee, stable, any_done;
    rs.res_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    repeat (5) tick();
    check_reset_vals("reset");
    start = 1;
    abort = 1;
    repeat (3) tick();
    check("start_abort_busy", busy, 0);
    start = 0;
    abort = 0;
    tick();
    check("start_abort_idle", busy, 0);
    tog_mode = 1;
    start = 1;
    tick();
    start = 0;
    cyc = 1;
    check("sweep_busy_t1", busy, 1);
    check("sweep_vec_t1", vec_out, 0);
    first_valid = 0; nrec = 0; n_osc = 0; done_cyc = 0; seen_ee = 0;
    while (cyc < 3400) begin
      if (rs.res_valid) begin
        if (first_valid == 0) first_valid = cyc;
        check("rec_vec", rs.res_vec, nrec);
        check("rec_osc", rs.res_osc, osc_model(8'(nrec)));
        check("rec_toggles", rs.res_toggles, 8);
        if (rs.res_osc) n_osc++;
        if (rs.res_osc && rs.res_vec == 8'hEE) seen_ee = 1;
        nrec++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
      cyc++;
    end
    check("first_valid_cycle", first_valid, 13);
    check("record_count", nrec, 256);
    check("osc_vectors", n_osc, 11);
    check("osc_ee_seen", seen_ee, 1);
    check("done_cycle", done_cyc, 3329);
    check("osc_count_final", osc_count, 11);
    check("vec_out_final", vec_out, 8'hFF);
    tick();
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("osc_count_hold", osc_count, 11);
    tog_mode = 0;
    start = 1;
    tick();
    start = 0;
    w = 0;
    while (!(rs.res_valid && rs.res_vec == 8'h05) && w < 200) begin
      tick();
      w++;
    end
    rs.res_ready = 0;
    check("reach_vec05", w < 200, 1);
    check("vec05_osc", rs.res_osc, 1);
    check("vec05_toggles_const", rs.res_toggles, 0);
    stable = 1;
    repeat (20) begin
      tick();
      if (!(rs.res_valid && rs.res_vec == 8'h05 && vec_out == 8'h05 && rs.res_osc)) stable = 0;
    end
    check("stall_stable", stable, 1);
    check("stall_osc_count", osc_count, 0);
    rs.res_ready = 1;
    tick();
    check("release_vec_out", vec_out, 8'h06);
    check("release_valid_low", rs.res_valid, 0);
    check("release_osc_count", osc_count, 1);
    w = 0;
    while (vec_out != 8'h10 && w < 200) begin
      tick();
      w++;
    end
    check("reach_vec10", w < 200, 1);
    repeat (SETTLE_CYC + 1) tick();
    check("observe_busy", busy, 1);
    abort = 1;
    tick();
    abort = 0;
    check("abort_busy", busy, 0);
    check("abort_valid", rs.res_valid, 0);
    check("abort_osc_count", osc_count, 1);
    check("abort_vec_hold", vec_out, 8'h10);
    any_done = 0;
    repeat (5) begin
      if (done) any_done = 1;
      tick();
    end
    check("abort_no_done", any_done, 0);
    tog_mode = 1;
    start = 1;
    tick();
    start = 0;
    check("restart_vec", vec_out, 0);
    check("restart_osc_count", osc_count, 0);
    check("restart_busy", busy, 1);
    w = 0;
    while (vec_out != 8'h02 && w < 100) begin
      tick();
      w++;
    end
    rs.res_ready = 0;
    w = 0;
    while (!rs.res_valid && w < 100) begin
      tick();
      w++;
    end
    check("report_vec02", rs.res_vec, 8'h02);
    check("report_toggles", rs.res_toggles, 8);
    #3;
    rst = 1;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rst = 0;
    tick();
    check("post_rst_idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
